f_ifu: RTL and testbench
========================

Name: f_ifu

Overview:
- Fetch stage of the 5-stage MIPS pipeline. Holds the architectural fetch PC (F_PC) and drives it to instruction memory.
- Each cycle it loads the next PC computed in D (D_NPC output). It captures the fetched word into the F/D pipeline register (D_PC, D_instr) for decode.
- It also detects fetch-address faults and pipes a fault flag into D.

Parameters:
- PC_RESET, 32'h0000_3000, value loaded into F_PC on reset.
- IM_BASE, 32'h0000_3000, byte address of the first instruction-memory word.
- IM_WORDS, 4096, instruction-memory depth in 32-bit words; legal fetch range is [IM_BASE, IM_BASE + 4*IM_WORDS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  from hazard unit; freezes F_PC and the F/D register.
- D_clr  input  1  clears the F/D register to a bubble.
- NPC  input  32  next PC from D-stage NPC logic.
- i_inst_rdata  input  32  instruction word at i_inst_addr, combinational from memory.
- i_inst_addr  output  32  fetch address; equals F_PC.
- F_PC  output  32  current fetch PC; consumed by NPC logic for PC+4.
- D_PC  output  32  PC of the instruction in D.
- D_instr  output  32  instruction in D.
- D_adel  output  1  instruction in D came from a faulting fetch address.

Behaviour:
- Reset (reset=1 at posedge) wins over every other input:
  - F_PC <= PC_RESET.
  - D_PC <= 0, D_instr <= 0 (sll $0 nop), D_adel <= 0.
- F_adel, combinational internal signal, is 1 when either holds:
  - F_PC[1:0] != 0;
  - F_PC < IM_BASE, or F_PC >= IM_BASE + 4*IM_WORDS (unsigned compare, 33-bit to avoid wrap).
- F_instr, combinational, is 32'h0 when F_adel=1, else i_inst_rdata. Faulting fetches never reach D as real opcodes.
- PC register:
  - stall=1: F_PC holds.
  - stall=0: F_PC <= NPC. No alignment correction; a bad NPC is latched and flagged via F_adel.
- F/D register, priority reset > D_clr > stall > load:
  - D_clr=1: D_PC <= 0, D_instr <= 0, D_adel <= 0, even if stall=1.
  - Else stall=1: hold D_PC, D_instr, D_adel.
  - Else: D_PC <= F_PC, D_instr <= F_instr, D_adel <= F_adel.
- stall and D_clr are independent for the PC: stall=1 with D_clr=1 holds F_PC and bubbles D.
- Latency: an instruction fetched at F_PC in cycle n appears on D_instr/D_PC in cycle n+1 when not stalled. Each stall cycle adds one cycle.
- Delay slot: no internal flush on branches. The instruction after a branch/jump is always delivered to D.
- Wrap-around: F_PC arithmetic is external. NPC = 32'hFFFF_FFFC followed by PC+4 = 0 is latched as-is; it is flagged as a fault because it is below IM_BASE.
- Reset asserted mid-stall or mid-clear: reset values are taken on that edge. The first fetch after reset deassertion is PC_RESET.
- i_inst_addr is always exactly F_PC, including during stall.

Decomposition:
- Shared header (def.v): `PC_RESET`, `IM_BASE`, `IM_WORDS`, `INSTR_NOP` (32'h0).
- One sub-module is natural: d_reg, the F/D pipeline register with reset/clear/stall priority. It is reused later for the D/E, E/M and M/W registers.
- The PC register and fault detect stay inline in f_ifu.

Test Plan:
- Reset held 2 cycles, then released with stall=0, NPC=F_PC+4, memory returns 32'h2408_0001 at 0x3000 -> F_PC=0x3000 after reset; next cycle F_PC=0x3004, D_PC=0x3000, D_instr=32'h2408_0001, D_adel=0.
- stall=1 for 3 cycles at F_PC=0x3008 with NPC=0x300C -> F_PC, D_PC and D_instr unchanged for all 3 cycles; first cycle after release: F_PC=0x300C, D_PC=0x3008.
- Jump: NPC=0x0000_3100 while F_PC=0x3010 -> next cycle F_PC=0x3100, D_PC=0x3010 (delay-slot instruction delivered, not squashed).
- Misaligned NPC=0x3102 -> F_PC=0x3102, i_inst_addr=0x3102; next cycle D_adel=1, D_instr=0, D_PC=0x3102. Out-of-range cases: NPC=0x2FFC and NPC=0x7000 (IM_WORDS=4096) both give D_adel=1.
- D_clr=1 with stall=1 at F_PC=0x3020 -> F_PC stays 0x3020; D_PC=0, D_instr=0, D_adel=0.
- Reset asserted while stall=1 and D_clr=1 -> F_PC=0x3000 and all D outputs zero on that edge.

Source files
------------

// File: rtl/f_ifu_pkg.sv
// Shared definitions for the fetch stage: reset PC, instruction-memory window,
// the bubble instruction, the F/D payload layout and the fetch-fault test.
package f_ifu_pkg;

  localparam logic [31:0] DEF_PC_RESET = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam int unsigned DEF_IM_WORDS = 4096;
  // sll $0,$0,0 -- the canonical MIPS nop used for bubbles
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;

  // Contents of the F/D pipeline register
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fd_t;

  localparam fd_t FD_BUBBLE = '{pc: 32'h0, instr: INSTR_NOP, adel: 1'b0};

  // A fetch faults when misaligned or outside [base, base + 4*words).
  // The compare is done on 33 bits so the upper bound cannot wrap.
  function automatic logic fetch_fault(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input int unsigned words);
    logic [32:0] addr;
    logic [32:0] lo;
    logic [32:0] hi;
    addr = {1'b0, pc};
    lo   = {1'b0, base};
    hi   = lo + (33'(words) << 2);
    return (pc[1:0] != 2'b00) || (addr < lo) || (addr >= hi);
  endfunction

endpackage

// File: rtl/f_ifu_d_reg.sv
// Generic pipeline register with priority reset > clear > stall > load.
// Used for F/D here and intended for the later D/E, E/M and M/W registers.
module f_ifu_d_reg #(
  parameter int unsigned   W       = 32,
  parameter logic [W-1:0]  CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         stall_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next value: a clear beats a stall so a bubble can be injected while frozen
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = CLR_VAL;
    end else if (!stall_i) begin
      data_d = data_i;
    end
  end

  // State register; reset overrides clear and stall
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= CLR_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/f_ifu.sv
// Fetch stage: holds the fetch PC, flags faulting fetch addresses and feeds
// the fetched word (or a nop on a fault) into the F/D register.
module f_ifu
  import f_ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = DEF_PC_RESET,
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter int unsigned IM_WORDS = DEF_IM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        D_clr,
  input  logic [31:0] NPC,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic        D_adel
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        f_adel;
  logic [31:0] f_instr;
  fd_t         fd_in;
  fd_t         fd_out;

  // Next PC: NPC is taken verbatim (no alignment fix), frozen by stall only;
  // D_clr affects the F/D register, never the PC
  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      pc_d = NPC;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Fault detect and squash: a faulting fetch must never reach D as a real opcode
  always_comb begin
    f_adel  = fetch_fault(pc_q, IM_BASE, IM_WORDS);
    f_instr = f_adel ? INSTR_NOP : i_inst_rdata;
    fd_in   = '{pc: pc_q, instr: f_instr, adel: f_adel};
  end

  f_ifu_d_reg #(
    .W       ($bits(fd_t)),
    .CLR_VAL (FD_BUBBLE)
  ) u_fd_reg (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (D_clr),
    .stall_i (stall),
    .data_i  (fd_in),
    .data_o  (fd_out)
  );

  assign i_inst_addr = pc_q;
  assign F_PC        = pc_q;
  assign D_PC        = fd_out.pc;
  assign D_instr     = fd_out.instr;
  assign D_adel      = fd_out.adel;

endmodule

// File: tb/tb_f_ifu.sv
// Scoreboard bench for f_ifu: the driver applies directed then random
// stimulus, a reference model pushes the expected post-edge state into a
// queue, and an independent monitor pops and compares after every edge.
module tb_f_ifu;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        D_clr;
  logic [31:0] NPC;
  logic [31:0] i_inst_rdata;
  logic [31:0] i_inst_addr;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic        D_adel;

  typedef struct {
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic [31:0] dinstr;
    logic        dadel;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  int total_cnt = 0;
  int pass_cnt  = 0;
  bit drv_done  = 0;

  // Reference model state
  logic [31:0] m_fpc;
  logic [31:0] m_dpc;
  logic [31:0] m_dinstr;
  logic        m_dadel;

  f_ifu dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .D_clr        (D_clr),
    .NPC          (NPC),
    .i_inst_rdata (i_inst_rdata),
    .i_inst_addr  (i_inst_addr),
    .F_PC         (F_PC),
    .D_PC         (D_PC),
    .D_instr      (D_instr),
    .D_adel       (D_adel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory content: any address returns some non-zero word,
  // so a missing fault squash is visible in D_instr
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0001;
    return (a * 32'h9E37_79B9) | 32'h0000_0100;
  endfunction

  always_comb i_inst_rdata = mem_word(i_inst_addr);

  // Legal fetch: word aligned and within [0x3000, 0x3000 + 4*4096)
  function automatic bit model_fault(input logic [31:0] pc);
    longint unsigned a;
    a = longint'(pc);
    return (a % 4 != 0) || (a < 64'h3000) || (a >= 64'h3000 + 4 * 4096);
  endfunction

  // Apply one cycle of inputs and queue what every output must be after the edge
  task automatic step(input bit rst, input bit stl, input bit clr,
                      input logic [31:0] npc, input string tag);
    exp_t e;
    bit   flt;
    @(negedge clk);
    reset = rst;
    stall = stl;
    D_clr = clr;
    NPC   = npc;
    flt   = model_fault(m_fpc);
    if (rst) begin
      m_fpc = 32'h3000; m_dpc = 0; m_dinstr = 0; m_dadel = 0;
    end else begin
      if (clr) begin
        m_dpc = 0; m_dinstr = 0; m_dadel = 0;
      end else if (!stl) begin
        m_dpc = m_fpc; m_dinstr = flt ? 32'h0 : mem_word(m_fpc); m_dadel = flt;
      end
      if (!stl) m_fpc = npc;
    end
    e.fpc = m_fpc; e.dpc = m_dpc; e.dinstr = m_dinstr; e.dadel = m_dadel; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Monitor: the DUT presents new state every edge; compare against the queue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".F_PC"},        F_PC,        e.fpc);
        chk({e.tag, ".i_inst_addr"}, i_inst_addr, e.fpc);
        chk({e.tag, ".D_PC"},        D_PC,        e.dpc);
        chk({e.tag, ".D_instr"},     D_instr,     e.dinstr);
        chk({e.tag, ".D_adel"},      {31'b0, D_adel}, {31'b0, e.dadel});
        $display("t=%0t %s rst=%0b stl=%0b clr=%0b NPC=%h -> F_PC=%h D_PC=%h D_instr=%h D_adel=%0b",
                 $time, e.tag, reset, stall, D_clr, NPC, F_PC, D_PC, D_instr, D_adel);
      end
    end
  end

  // Driver
  initial begin
    int r;
    logic [31:0] npc;
    reset = 1'b1; stall = 1'b0; D_clr = 1'b0; NPC = 32'h0;
    m_fpc = 'x; m_dpc = 'x; m_dinstr = 'x; m_dadel = 1'bx;

    step(1, 0, 0, 32'h0, "reset0");
    step(1, 0, 0, 32'h0, "reset1");
    step(0, 0, 0, m_fpc + 4, "seq0");
    step(0, 0, 0, m_fpc + 4, "seq1");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h300C, "stall");
    step(0, 0, 0, 32'h300C, "unstall");
    step(0, 0, 0, m_fpc + 4, "seq2");
    step(0, 0, 0, 32'h3100, "jump");
    step(0, 0, 0, 32'h3102, "delay_slot");
    step(0, 0, 0, 32'h2FFC, "misalign");
    step(0, 0, 0, 32'h7000, "below_base");
    step(0, 0, 0, 32'h6FFC, "above_top");
    step(0, 0, 0, 32'h3020, "last_word");
    step(0, 0, 0, 32'h3024, "to_3020");
    step(0, 1, 1, 32'h3024, "clr_stall");
    step(0, 0, 0, 32'hFFFF_FFFC, "to_wrap");
    step(0, 0, 0, 32'h0000_0000, "wrap_hi");
    step(0, 0, 0, 32'h0000_0004, "wrap_zero");
    step(0, 1, 1, 32'h3008, "pre_rst");
    step(1, 1, 1, 32'h3008, "rst_stall_clr");
    step(0, 0, 0, m_fpc + 4, "post_rst");

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)       npc = m_fpc + 4;
      else if (r < 85)  npc = 32'h3000 + ($urandom_range(0, 4095) << 2);
      else if (r < 92)  npc = 32'h3000 + $urandom_range(0, 16383);
      else              npc = $urandom;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 10, npc, "rand");
    end

    repeat (3) @(negedge clk);
    drv_done = 1;
  end

  // End of run: everything queued must have been checked
  initial begin
    fork
      wait (drv_done);
      #100000;
    join_any
    total_cnt++;
    if (drv_done && exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: done=%0b pending=%0d expected done=1 pending=0", drv_done, exp_q.size());
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
